forwarding_hazard_unit: RTL and testbench
=========================================

// Module: forwarding_hazard_unit
// PURPOSE
//  Per-operand data forwarding plus load-use interlock for the 5-stage RV32I pipeline.
//  - Sits between ID/EX and the EX-stage operand muxes.
//  - Generalised to NUM_SRC source operands and a configurable number of load-use bubbles.
//  - Adds a per-operand capture register, so forwarded values survive while EX is held
//    (multicycle op) and MEM/WB keep draining.
// PARAMETERS
//  WIDTH            32  datapath width of operands
//  NUM_SRC          2   number of EX-stage source operands (1..4)
//  LOAD_USE_BUBBLES 1   bubbles inserted on a load-use hazard (1..3)
// PORTS
//  clk               in   1              rising-edge clock
//  rst               in   1              synchronous, active-high reset
//  flush_i           in   1              squash (branch/jump redirect); sync clear of state
//  pipe_stall_i      in   1              global freeze (cache miss); all stages hold
//  ex_hold_i         in   1              EX holds; MEM and WB advance (bubbles into MEM)
//  id_rs_i           in   NUM_SRC*5      ID-stage source register indices
//  id_rs_used_i      in   NUM_SRC        ID-stage source k actually read
//  ex_rs_i           in   NUM_SRC*5      EX-stage source register indices
//  ex_rs_data_i      in   NUM_SRC*WIDTH  regfile values latched in ID/EX
//  ex_rd_i           in   5              EX-stage destination register
//  ex_load_regfile_i in   1              EX-stage instruction writes rd
//  ex_is_load_i      in   1              EX-stage instruction is a load
//  mem_rd_i          in   5              EX/MEM destination register
//  mem_load_regfile_i in  1              EX/MEM writes rd
//  mem_data_i        in   WIDTH          EX/MEM forwardable result
//  wb_rd_i           in   5              MEM/WB destination register
//  wb_load_regfile_i in   1              MEM/WB writes rd
//  wb_data_i         in   WIDTH          MEM/WB writeback value
//  fwd_sel_o         out  NUM_SRC*2      per-operand select: 00 id_ex, 01 ex_mem, 10 mem_wb, 11 held
//  operand_o         out  NUM_SRC*WIDTH  resolved EX operands
//  load_use_stall_o  out  1              freeze PC and IF/ID
//  bubble_o          out  1              load a NOP into ID/EX
// BEHAVIOUR
//  Forwarding select (combinational, per operand k, independent of other operands):
//  - ex_rs[k]==0 -> 00, always.
//  - Otherwise, in priority order: hold_valid[k] -> 11; then EX/MEM match (mem_load_regfile
//    & mem_rd!=0 & mem_rd==ex_rs[k]) -> 01; then MEM/WB match (same form) -> 10; else 00.
//  - EX/MEM strictly wins over MEM/WB on the same rd.
//  - operand_o[k] is the matching input for the select: ex_rs_data, mem_data, wb_data,
//    or hold_data[k].
//  Capture register (per operand k):
//  - At an edge with ex_hold_i=1, pipe_stall_i=0 and hold_valid[k]=0: hold_data[k] <=
//    operand_o[k] and hold_valid[k] <= 1. Capture is unconditional on the current select.
//  - While hold_valid[k]=1, hold_data[k] does not change.
//  - At an edge with ex_hold_i=0 and pipe_stall_i=0 (EX advances): hold_valid[k] <= 0.
//  - pipe_stall_i=1 freezes all hold state.
//  - Result: a producer that retires from WB during an EX hold is not lost.
//  Load-use FSM (states IDLE, LU_STALL; counter cnt of width $clog2(LOAD_USE_BUBBLES+1)):
//  - hazard = ex_is_load & ex_load_regfile & ex_rd!=0 & OR_k(id_rs_used[k] & id_rs[k]==ex_rd).
//  - IDLE: load_use_stall_o = bubble_o = hazard. At an edge with hazard & !pipe_stall &
//    !ex_hold and LOAD_USE_BUBBLES>1: go to LU_STALL with cnt <= LOAD_USE_BUBBLES-1.
//  - LU_STALL: load_use_stall_o = bubble_o = 1.
//    - Each edge with !pipe_stall_i: cnt decrements.
//    - Edge with cnt==1 and !pipe_stall_i: go to IDLE.
//    - pipe_stall_i=1 freezes state and cnt; outputs stay asserted.
//  - The regfile writes through on WB, so the consumer leaving ID sees the load result.
//  Flush and reset:
//  - flush_i (below rst, above everything else): next state IDLE, cnt 0, all hold_valid 0.
//    load_use_stall_o and bubble_o are forced 0 in the flush cycle.
//  - rst: hold_valid=0, hold_data=0, state IDLE, cnt=0.
//  - After reset, outputs are purely combinational from the inputs: fwd_sel 00 and
//    stall/bubble 0 when no match. Reset mid-hold or mid-stall discards that state
//    in the same edge.
// TESTING
//  1 ex_rs0=ex_rs1=5; mem_rd=5, mem_ld=1, mem_data=0x11; wb_rd=5, wb_ld=1, wb_data=0x22
//    -> both fwd_sel=01, operand=0x11.
//  2 ex_rs0=0; mem_rd=0, mem_ld=1; ex_rs_data0=0xABCD -> sel 00, operand 0xABCD.
//    Also: wb_rd=9 match on rs1 only -> sel1=10, sel0 unaffected.
//  3 ex_rs1=7; wb_rd=7, wb_data=0xDEADBEEF; ex_hold_i=1 for 3 cycles; wb_data -> 0 after
//    edge 1 -> cycles 2-3 sel1=11, operand1=0xDEADBEEF. ex_hold_i=0 -> next cycle
//    hold_valid=0.
//  4 LOAD_USE_BUBBLES=2; ex_is_load, ex_rd=3; id_rs0=3, used -> stall/bubble high 2 cycles.
//    pipe_stall_i=1 for 4 cycles after edge 1 -> stall high 6 cycles total, then IDLE.
//  5 flush_i in LU_STALL -> stall=0 in the flush cycle, IDLE next.
//    flush_i during hold -> sel returns to comb value next cycle.
//  6 rst for 1 cycle with hold_valid=1 and FSM in LU_STALL -> next cycle sel from inputs,
//    stall 0, hold_data=0.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding and load-use interlock for the EX stage of the 5-stage pipeline.
// Each operand has a capture register so a forwarded value survives while EX is held
// and MEM/WB keep draining underneath it.
module forwarding_hazard_unit #(
    parameter int unsigned WIDTH            = 32,
    parameter int unsigned NUM_SRC          = 2,
    parameter int unsigned LOAD_USE_BUBBLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     pipe_stall_i,
    input  logic                     ex_hold_i,
    input  logic [NUM_SRC*5-1:0]     id_rs_i,
    input  logic [NUM_SRC-1:0]       id_rs_used_i,
    input  logic [NUM_SRC*5-1:0]     ex_rs_i,
    input  logic [NUM_SRC*WIDTH-1:0] ex_rs_data_i,
    input  logic [4:0]               ex_rd_i,
    input  logic                     ex_load_regfile_i,
    input  logic                     ex_is_load_i,
    input  logic [4:0]               mem_rd_i,
    input  logic                     mem_load_regfile_i,
    input  logic [WIDTH-1:0]         mem_data_i,
    input  logic [4:0]               wb_rd_i,
    input  logic                     wb_load_regfile_i,
    input  logic [WIDTH-1:0]         wb_data_i,
    output logic [NUM_SRC*2-1:0]     fwd_sel_o,
    output logic [NUM_SRC*WIDTH-1:0] operand_o,
    output logic                     load_use_stall_o,
    output logic                     bubble_o
);

    localparam int unsigned CntW = $clog2(LOAD_USE_BUBBLES + 1);

    typedef enum logic [0:0] {StIdle, StLuStall} state_e;

    state_e                          state_q;
    logic [CntW-1:0]                 cnt_q;
    logic [NUM_SRC-1:0]              hold_valid_q;
    logic [NUM_SRC-1:0][WIDTH-1:0]   hold_data_q;
    logic [NUM_SRC-1:0][1:0]         sel;
    logic [NUM_SRC-1:0]              id_hit;
    logic                            hazard;

    // Per-operand source select: x0 never forwards, held value beats the youngest producer.
    always_comb begin
        sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ex_rs_i[k*5 +: 5] != 5'd0) begin
                if (hold_valid_q[k]) begin
                    sel[k] = 2'b11;
                end else if (mem_load_regfile_i && (mem_rd_i != 5'd0) &&
                             (mem_rd_i == ex_rs_i[k*5 +: 5])) begin
                    sel[k] = 2'b01;
                end else if (wb_load_regfile_i && (wb_rd_i != 5'd0) &&
                             (wb_rd_i == ex_rs_i[k*5 +: 5])) begin
                    sel[k] = 2'b10;
                end
            end
        end
    end

    // Operand mux driven by the select.
    always_comb begin
        fwd_sel_o = '0;
        operand_o = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            fwd_sel_o[k*2 +: 2] = sel[k];
            unique case (sel[k])
                2'b00: operand_o[k*WIDTH +: WIDTH] = ex_rs_data_i[k*WIDTH +: WIDTH];
                2'b01: operand_o[k*WIDTH +: WIDTH] = mem_data_i;
                2'b10: operand_o[k*WIDTH +: WIDTH] = wb_data_i;
                2'b11: operand_o[k*WIDTH +: WIDTH] = hold_data_q[k];
            endcase
        end
    end

    // Load-use hazard: a load in EX writes a register that the ID instruction reads.
    always_comb begin
        id_hit = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            id_hit[k] = id_rs_used_i[k] && (id_rs_i[k*5 +: 5] == ex_rd_i);
        end
        hazard = ex_is_load_i && ex_load_regfile_i && (ex_rd_i != 5'd0) && (|id_hit);
    end

    // Stall/bubble: combinational in IDLE, forced during the extra bubbles, killed by flush.
    always_comb begin
        load_use_stall_o = 1'b0;
        if (flush_i) begin
            load_use_stall_o = 1'b0;
        end else if (state_q == StLuStall) begin
            load_use_stall_o = 1'b1;
        end else begin
            load_use_stall_o = hazard;
        end
        bubble_o = load_use_stall_o;
    end

    // Load-use FSM: the first bubble comes from IDLE, the remaining ones are counted here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else if (flush_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else if (!pipe_stall_i) begin
            unique case (state_q)
                StIdle: begin
                    if (hazard && !ex_hold_i && (LOAD_USE_BUBBLES > 1)) begin
                        state_q <= StLuStall;
                        cnt_q   <= CntW'(LOAD_USE_BUBBLES - 1);
                    end
                end
                StLuStall: begin
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    // Capture registers: latch the resolved operand on the first held edge, drop when EX moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= '0;
            hold_data_q  <= '0;
        end else if (flush_i) begin
            hold_valid_q <= '0;
        end else if (!pipe_stall_i) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (ex_hold_i) begin
                    if (!hold_valid_q[k]) begin
                        hold_data_q[k]  <= operand_o[k*WIDTH +: WIDTH];
                        hold_valid_q[k] <= 1'b1;
                    end
                end else begin
                    hold_valid_q[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit: directed scenarios followed by a
// randomized run, all checked against a behavioural model of the forwarding rules.
module tb_forwarding_hazard_unit;

    localparam int unsigned W   = 32;
    localparam int unsigned NS  = 2;
    localparam int unsigned LUB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus
    logic          rst, flush, pipe_stall, ex_hold;
    logic [4:0]    id_rs [NS];
    logic          id_used [NS];
    logic [4:0]    ex_rs [NS];
    logic [W-1:0]  ex_data [NS];
    logic [4:0]    ex_rd, mem_rd, wb_rd;
    logic          ex_ld_rf, ex_is_load, mem_ld, wb_ld;
    logic [W-1:0]  mem_data, wb_data;

    // DUT buses
    logic [NS*5-1:0] id_rs_bus, ex_rs_bus;
    logic [NS-1:0]   id_used_bus;
    logic [NS*W-1:0] ex_data_bus, operand_bus;
    logic [NS*2-1:0] sel_bus;
    logic            stall, bubble;

    assign id_rs_bus   = {id_rs[1], id_rs[0]};
    assign ex_rs_bus   = {ex_rs[1], ex_rs[0]};
    assign id_used_bus = {id_used[1], id_used[0]};
    assign ex_data_bus = {ex_data[1], ex_data[0]};

    forwarding_hazard_unit #(
        .WIDTH            (W),
        .NUM_SRC          (NS),
        .LOAD_USE_BUBBLES (LUB)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .flush_i            (flush),
        .pipe_stall_i       (pipe_stall),
        .ex_hold_i          (ex_hold),
        .id_rs_i            (id_rs_bus),
        .id_rs_used_i       (id_used_bus),
        .ex_rs_i            (ex_rs_bus),
        .ex_rs_data_i       (ex_data_bus),
        .ex_rd_i            (ex_rd),
        .ex_load_regfile_i  (ex_ld_rf),
        .ex_is_load_i       (ex_is_load),
        .mem_rd_i           (mem_rd),
        .mem_load_regfile_i (mem_ld),
        .mem_data_i         (mem_data),
        .wb_rd_i            (wb_rd),
        .wb_load_regfile_i  (wb_ld),
        .wb_data_i          (wb_data),
        .fwd_sel_o          (sel_bus),
        .operand_o          (operand_bus),
        .load_use_stall_o   (stall),
        .bubble_o           (bubble)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit           m_hv [NS];
    logic [W-1:0] m_hd [NS];
    int           m_lu_left;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_sel(input int k);
        if (ex_rs[k] == 5'd0) return 2'b00;
        if (m_hv[k]) return 2'b11;
        if (mem_ld && mem_rd != 5'd0 && mem_rd == ex_rs[k]) return 2'b01;
        if (wb_ld && wb_rd != 5'd0 && wb_rd == ex_rs[k]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [W-1:0] exp_operand(input int k);
        case (exp_sel(k))
            2'b01:   return mem_data;
            2'b10:   return wb_data;
            2'b11:   return m_hd[k];
            default: return ex_data[k];
        endcase
    endfunction

    function automatic bit hazard_now();
        bit hit = 0;
        for (int k = 0; k < NS; k++) if (id_used[k] && id_rs[k] == ex_rd) hit = 1;
        return ex_is_load && ex_ld_rf && ex_rd != 5'd0 && hit;
    endfunction

    function automatic logic exp_stall();
        if (flush) return 1'b0;
        if (m_lu_left > 0) return 1'b1;
        return hazard_now();
    endfunction

    // Compare every output against the model, away from the active edge.
    task automatic sample(input string tag);
        @(negedge clk);
        for (int k = 0; k < NS; k++) begin
            chk($sformatf("%s sel%0d", tag, k), 64'(sel_bus[k*2 +: 2]), 64'(exp_sel(k)));
            chk($sformatf("%s op%0d", tag, k), 64'(operand_bus[k*W +: W]),
                64'(exp_operand(k)));
        end
        chk({tag, " stall"}, 64'(stall), 64'(exp_stall()));
        chk({tag, " bubble"}, 64'(bubble), 64'(exp_stall()));
    endtask

    // Advance the model across the clock edge using the pre-edge inputs.
    task automatic tick();
        logic [W-1:0] cap [NS];
        @(posedge clk);
        for (int k = 0; k < NS; k++) cap[k] = exp_operand(k);
        if (rst) begin
            for (int k = 0; k < NS; k++) begin
                m_hv[k] = 0;
                m_hd[k] = '0;
            end
            m_lu_left = 0;
        end else if (flush) begin
            for (int k = 0; k < NS; k++) m_hv[k] = 0;
            m_lu_left = 0;
        end else if (!pipe_stall) begin
            for (int k = 0; k < NS; k++) begin
                if (ex_hold) begin
                    if (!m_hv[k]) begin
                        m_hd[k] = cap[k];
                        m_hv[k] = 1;
                    end
                end else begin
                    m_hv[k] = 0;
                end
            end
            if (m_lu_left > 0) m_lu_left--;
            else if (hazard_now() && !ex_hold) m_lu_left = LUB - 1;
        end
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; pipe_stall = 0; ex_hold = 0;
        for (int k = 0; k < NS; k++) begin
            id_rs[k] = '0; id_used[k] = 0; ex_rs[k] = '0; ex_data[k] = '0;
        end
        ex_rd = '0; mem_rd = '0; wb_rd = '0;
        ex_ld_rf = 0; ex_is_load = 0; mem_ld = 0; wb_ld = 0;
        mem_data = '0; wb_data = '0;
    endtask

    task automatic set_load_hazard(input bit on);
        ex_is_load = on; ex_ld_rf = on; ex_rd = 5'd3;
        id_rs[0] = 5'd3; id_used[0] = on;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NS; k++) begin
            m_hv[k] = 0;
            m_hd[k] = '0;
        end
        m_lu_left = 0;
        clear_inputs();
        rst = 1;
        sample("reset");
        tick();
        rst = 0;
        sample("post_reset");
        chk("post_reset sel", 64'(sel_bus), 64'h0);
        tick();

        // 1: EX/MEM beats MEM/WB on the same rd
        ex_rs[0] = 5; ex_rs[1] = 5;
        mem_rd = 5; mem_ld = 1; mem_data = 32'h11;
        wb_rd = 5; wb_ld = 1; wb_data = 32'h22;
        sample("t1");
        chk("t1 sel", 64'(sel_bus), 64'h5);
        chk("t1 ops", 64'(operand_bus), 64'h0000_0011_0000_0011);
        tick();

        // 2: x0 never forwards; WB match on one operand only
        clear_inputs();
        ex_rs[0] = 0; mem_rd = 0; mem_ld = 1; ex_data[0] = 32'hABCD;
        ex_rs[1] = 9; wb_rd = 9; wb_ld = 1; wb_data = 32'h99;
        sample("t2");
        chk("t2 sel", 64'(sel_bus), 64'h8);
        chk("t2 op0", 64'(operand_bus[W-1:0]), 64'hABCD);
        tick();

        // 3: value captured during EX hold outlives the WB producer
        clear_inputs();
        ex_rs[1] = 7; wb_rd = 7; wb_ld = 1; wb_data = 32'hDEADBEEF; ex_hold = 1;
        sample("t3 c1");
        tick();
        wb_data = '0;
        for (int c = 2; c <= 3; c++) begin
            sample($sformatf("t3 c%0d", c));
            chk("t3 held sel1", 64'(sel_bus[3:2]), 64'h3);
            chk("t3 held op1", 64'(operand_bus[2*W-1:W]), 64'hDEADBEEF);
            tick();
        end
        ex_hold = 0;
        sample("t3 release");
        tick();
        sample("t3 after");
        chk("t3 after sel1", 64'(sel_bus[3:2]), 64'h2);
        tick();

        // 4: two-bubble load-use, stretched by a 4-cycle pipeline freeze
        clear_inputs();
        set_load_hazard(1);
        sample("t4 c1");
        chk("t4 c1 stall", 64'(stall), 64'h1);
        tick();
        pipe_stall = 1;
        for (int c = 0; c < 4; c++) begin
            sample("t4 frozen");
            chk("t4 frozen stall", 64'(stall), 64'h1);
            tick();
        end
        pipe_stall = 0;
        set_load_hazard(0);
        sample("t4 last");
        chk("t4 last stall", 64'(stall), 64'h1);
        tick();
        sample("t4 idle");
        chk("t4 idle stall", 64'(stall), 64'h0);
        tick();

        // 5a: flush out of LU_STALL
        set_load_hazard(1);
        sample("t5 enter");
        tick();
        flush = 1;
        sample("t5 flush");
        chk("t5 flush stall", 64'(stall), 64'h0);
        tick();
        flush = 0;
        set_load_hazard(0);
        sample("t5 idle");
        tick();

        // 5b: flush drops the capture while EX is still held
        clear_inputs();
        ex_rs[1] = 7; wb_rd = 7; wb_ld = 1; wb_data = 32'h1234; ex_hold = 1;
        sample("t5b cap");
        tick();
        wb_data = 32'h5678;
        flush = 1;
        sample("t5b flush");
        chk("t5b flush op1", 64'(operand_bus[2*W-1:W]), 64'h1234);
        tick();
        flush = 0;
        sample("t5b after");
        chk("t5b after sel1", 64'(sel_bus[3:2]), 64'h2);
        chk("t5b after op1", 64'(operand_bus[2*W-1:W]), 64'h5678);
        tick();

        // 6: reset discards stall and hold state in the same edge
        clear_inputs();
        set_load_hazard(1);
        sample("t6 enter");
        tick();
        set_load_hazard(0);
        rst = 1;
        sample("t6 rst");
        tick();
        rst = 0;
        sample("t6 after");
        chk("t6 after stall", 64'(stall), 64'h0);
        tick();
        ex_rs[0] = 4; wb_rd = 4; wb_ld = 1; wb_data = 32'hCAFE; ex_hold = 1;
        sample("t6 cap");
        tick();
        rst = 1;
        sample("t6 rst2");
        tick();
        rst = 0;
        wb_data = 32'hBEEF;
        sample("t6 after2");
        chk("t6 after2 sel0", 64'(sel_bus[1:0]), 64'h2);
        tick();

        // Randomized run against the model
        clear_inputs();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            pipe_stall = ($urandom_range(0, 4) == 0);
            ex_hold    = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < NS; k++) begin
                id_rs[k]   = 5'($urandom_range(0, 3));
                id_used[k] = $urandom_range(0, 1) == 1;
                ex_rs[k]   = 5'($urandom_range(0, 3));
                ex_data[k] = $urandom;
            end
            ex_rd      = 5'($urandom_range(0, 3));
            ex_ld_rf   = $urandom_range(0, 3) != 0;
            ex_is_load = $urandom_range(0, 1) == 1;
            mem_rd     = 5'($urandom_range(0, 3));
            mem_ld     = $urandom_range(0, 1) == 1;
            mem_data   = $urandom;
            wb_rd      = 5'($urandom_range(0, 3));
            wb_ld      = $urandom_range(0, 1) == 1;
            wb_data    = $urandom;
            sample($sformatf("rnd%0d", i));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
